// File: rtl/data_mem_responder.sv
// Wait-state data memory responder for the 19-bit CPU bus; one access in flight.
// Optional define DMEM_PARITY_EN adds a stored even-parity bit and a par_inject port.
module data_mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [18:0] address,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [18:0] wr_data,
`ifdef DMEM_PARITY_EN
    input  logic        par_inject,
`endif
    output logic [18:0] rd_data,
    output logic        ready,
    output logic        err,
    output logic        busy
);
    localparam int DEPTH = 2 ** ADDR_W;
`ifdef DMEM_PARITY_EN
    localparam int MEM_W = 20;
`else
    localparam int MEM_W = 19;
`endif
    localparam logic [3:0] WS_LOAD =
        (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              op_rd;
    logic              op_wr;
    logic [18:0]       op_addr;
    logic [18:0]       op_data;
    logic [MEM_W-1:0]  mem [DEPTH];

    logic              in_idle;
    logic              req;
    logic              go_resp;
    logic              c_rd;
    logic              c_wr;
    logic              c_bad;
    logic [18:0]       c_addr;
    logic [18:0]       c_data;
    logic [ADDR_W-1:0] c_idx;
    logic [MEM_W-1:0]  c_word;
    logic [MEM_W-1:0]  w_word;
    logic              we;
    logic              par_bad;
`ifdef DMEM_PARITY_EN
    logic              op_inj;
    logic              c_inj;
`endif

    // With zero wait states the access happens on the accept edge itself,
    // so the live bus is used; otherwise the latched request is.
    always_comb begin
        in_idle = (state == IDLE);
        req     = mem_read | mem_write;
        c_rd    = in_idle ? mem_read  : op_rd;
        c_wr    = in_idle ? mem_write : op_wr;
        c_addr  = in_idle ? address   : op_addr;
        c_data  = in_idle ? wr_data   : op_data;
        c_bad   = ((c_addr >> ADDR_W) != 19'd0) || (c_rd && c_wr);
        go_resp = (in_idle && req && (WAIT_STATES == 0))
                || ((state == WAIT) && (cnt == 4'd0));
        we      = go_resp && c_wr && !c_bad && !rst;
        c_idx   = c_addr[ADDR_W-1:0];
        c_word  = mem[c_idx];
`ifdef DMEM_PARITY_EN
        c_inj   = in_idle ? par_inject : op_inj;
        w_word  = {(^c_data) ^ c_inj, c_data};
        par_bad = ^c_word;
`else
        w_word  = c_data;
        par_bad = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (we)
            mem[c_idx] <= w_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            rd_data <= 19'd0;
            ready   <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
            op_rd   <= 1'b0;
            op_wr   <= 1'b0;
            op_addr <= 19'd0;
            op_data <= 19'd0;
`ifdef DMEM_PARITY_EN
            op_inj  <= 1'b0;
`endif
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            if (go_resp) begin
                state <= RESP;
                ready <= 1'b1;
                busy  <= 1'b1;
                if (c_bad) begin
                    err <= 1'b1;
                end else if (c_rd) begin
                    rd_data <= c_word[18:0];
                    err     <= par_bad;
                end
            end else begin
                unique case (state)
                    IDLE: begin
                        if (req) begin
                            state   <= WAIT;
                            busy    <= 1'b1;
                            cnt     <= WS_LOAD;
                            op_rd   <= mem_read;
                            op_wr   <= mem_write;
                            op_addr <= address;
                            op_data <= wr_data;
`ifdef DMEM_PARITY_EN
                            op_inj  <= par_inject;
`endif
                        end
                    end
                    WAIT: cnt <= cnt - 4'd1;
                    RESP: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed table, hand-built corner sequences,
// then random traffic against an array-based model of the memory.
module tb_data_mem_responder;
    localparam int WS = 2;

    logic        clk;
    logic        rst;
    logic [18:0] address;
    logic        mem_read;
    logic        mem_write;
    logic [18:0] wr_data;
    logic        par_inject;
    logic [18:0] rd_data;
    logic        ready;
    logic        err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    data_mem_responder #(.ADDR_W(8), .WAIT_STATES(WS)) dut (
        .clk(clk),
        .rst(rst),
        .address(address),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .wr_data(wr_data),
`ifdef DMEM_PARITY_EN
        .par_inject(par_inject),
`endif
        .rd_data(rd_data),
        .ready(ready),
        .err(err),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [18:0] addr;
        logic [18:0] data;
        logic        e_err;
        logic [18:0] e_data;
    } vec_t;

    logic [18:0] m_mem [256];
    bit          m_bad [256];
    logic [18:0] m_last;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic access(input logic rd, input logic wr,
                          input logic [18:0] a, input logic [18:0] d,
                          input logic inj, input logic e_err,
                          input logic [18:0] e_data, input string tag);
        int lat;
        @(negedge clk);
        mem_read   = rd;
        mem_write  = wr;
        address    = a;
        wr_data    = d;
        par_inject = inj;
        @(posedge clk);
        @(negedge clk);
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        wr_data    = 'z;
        par_inject = 1'b0;
        check({tag, " busy"}, 32'(busy), 32'd1);
        lat = 1;
        while (!ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, WS + 1);
        check({tag, " err"}, 32'(err), 32'(e_err));
        check({tag, " rd_data"}, 32'(rd_data), 32'(e_data));
        @(negedge clk);
        check({tag, " pulse end"}, {29'd0, ready, err, busy}, 32'd0);
    endtask

    vec_t tbl [13];

    initial begin
        logic [18:0] a;
        logic [18:0] d;
        logic        rd;
        logic        wr;
        logic        inj;
        logic        e_err;
        bit          oob;
        int          kind;

        rst        = 1'b0;
        address    = 19'd0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        wr_data    = 19'd0;
        par_inject = 1'b0;

        // reset takes effect with no clock edge
        #2 rst = 1'b1;
        #1;
        check("reset async outputs", {10'd0, rd_data, ready, err, busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        tbl[0]  = '{1'b0, 1'b1, 19'h00010, 19'h5A5A5, 1'b0, 19'h00000};
        tbl[1]  = '{1'b1, 1'b0, 19'h00010, 19'h00000, 1'b0, 19'h5A5A5};
        tbl[2]  = '{1'b1, 1'b0, 19'h00100, 19'h00000, 1'b1, 19'h5A5A5};
        tbl[3]  = '{1'b0, 1'b1, 19'h00000, 19'h00001, 1'b0, 19'h5A5A5};
        tbl[4]  = '{1'b0, 1'b1, 19'h00100, 19'h12345, 1'b1, 19'h5A5A5};
        tbl[5]  = '{1'b1, 1'b0, 19'h00000, 19'h00000, 1'b0, 19'h00001};
        tbl[6]  = '{1'b0, 1'b1, 19'h00020, 19'h0AAAA, 1'b0, 19'h00001};
        tbl[7]  = '{1'b1, 1'b1, 19'h00020, 19'h11111, 1'b1, 19'h00001};
        tbl[8]  = '{1'b1, 1'b0, 19'h00020, 19'h00000, 1'b0, 19'h0AAAA};
        tbl[9]  = '{1'b0, 1'b1, 19'h00030, 19'h00001, 1'b0, 19'h0AAAA};
        tbl[10] = '{1'b1, 1'b0, 19'h7FFFF, 19'h00000, 1'b1, 19'h0AAAA};
        tbl[11] = '{1'b0, 1'b1, 19'h000FF, 19'h3FFFF, 1'b0, 19'h0AAAA};
        tbl[12] = '{1'b1, 1'b0, 19'h000FF, 19'h00000, 1'b0, 19'h3FFFF};

        for (int i = 0; i < 13; i++)
            access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data, 1'b0,
                   tbl[i].e_err, tbl[i].e_data, $sformatf("vec%0d", i));

        // read held across the busy window: only re-accepted once idle
        @(negedge clk);
        mem_read = 1'b1;
        address  = 19'h00010;
        @(posedge clk);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1)
                address = 19'h00020;
            if (c == 5)
                mem_read = 1'b0;
            check($sformatf("held read ready c%0d", c), 32'(ready),
                  32'((c == 3) || (c == 7)));
            if (c == 3)
                check("held read data1", 32'(rd_data), 32'h5A5A5);
            if (c == 7)
                check("held read data2", 32'(rd_data), 32'h0AAAA);
        end

        // reset in WAIT abandons a write
        @(negedge clk);
        mem_write = 1'b1;
        address   = 19'h00030;
        wr_data   = 19'h7FFFF;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid-op reset outputs",
              {10'd0, rd_data, ready, err, busy}, 32'd0);
        mem_write = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            check($sformatf("abandoned no ready c%0d", c),
                  {30'd0, ready, busy}, 32'd0);
        end
        access(1'b1, 1'b0, 19'h00030, 19'h0, 1'b0, 1'b0, 19'h00001,
               "post-reset read");
        m_last = 19'h00001;

`ifdef DMEM_PARITY_EN
        access(1'b0, 1'b1, 19'h00040, 19'h13579, 1'b1, 1'b0, 19'h00001,
               "parity inject write");
        access(1'b1, 1'b0, 19'h00040, 19'h0, 1'b0, 1'b1, 19'h13579,
               "parity bad read");
        m_last = 19'h13579;
`endif

        for (int i = 0; i < 256; i++) begin
            d = 19'($urandom);
            access(1'b0, 1'b1, 19'(i), d, 1'b0, 1'b0, m_last, "init");
            m_mem[i] = d;
            m_bad[i] = 1'b0;
        end

        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 9);
            oob  = (kind == 9);
            rd   = (kind < 4) || (kind == 8) || (oob && $urandom_range(0, 1) == 1);
            wr   = ((kind >= 4) && (kind < 8)) || (kind == 8) || (oob && !rd);
            a    = oob ? 19'($urandom_range(256, 19'h7FFFF))
                       : 19'($urandom_range(0, 255));
            d    = 19'($urandom);
`ifdef DMEM_PARITY_EN
            inj  = ($urandom_range(0, 3) == 0);
`else
            inj  = 1'b0;
`endif
            e_err = oob || (rd && wr);
            if (!e_err) begin
                if (wr) begin
                    m_mem[a[7:0]] = d;
                    m_bad[a[7:0]] = inj;
                end else begin
                    e_err  = m_bad[a[7:0]];
                    m_last = m_mem[a[7:0]];
                end
            end
            access(rd, wr, a, d, inj, e_err, m_last, $sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
